// File: rtl/lepton_vospi_emulator.sv
// Camera-side VoSPI responder: streams 164-byte Lepton packets (video lines, then discards) as an SPI slave.
// Define LEPTON_EMU_CRC_EN to build the CRC-16-CCITT engine; otherwise the CRC field is always zero.
module lepton_vospi_emulator #(
  parameter int LINES        = 60,
  parameter int DISCARD_PKTS = 4
) (
  input  logic CLK_25,
  input  logic RST,
  input  logic CAM_CS,
  input  logic CAM_CLK,
  output logic CAM_MISO,
  output logic PKT_SENT,
  output logic FRAME_DONE,
  output logic dbg_state
);
  localparam logic [6:0]  FIRST_DISC = 7'(LINES);
  localparam logic [6:0]  LAST_LINE  = 7'(LINES - 1);
  localparam logic [6:0]  LAST_POS   = 7'(LINES + DISCARD_PKTS - 1);
  localparam logic [10:0] LAST_BIT   = 11'd1311;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, state_next;

  logic        cam_clk_q, rise, last_edge, seq_adv;
  logic [10:0] bit_cnt, bit_cnt_next;
  logic [6:0]  head_pos;
  logic [7:0]  head_frame;
  logic        force_disc, cur_disc, cur_valid;
  logic [15:0] crc_cur, cur_word;

  function automatic logic [6:0] adv_pos(input logic [6:0] p);
    return (p == LAST_POS) ? 7'd0 : p + 7'd1;
  endfunction

  // Word w of a packet with the CRC field reading as zero; positions >= LINES are discards.
  function automatic logic [15:0] pkt_word(input logic disc, input logic [5:0] line,
                                           input logic f0, input logic [6:0] w);
    logic [6:0] col;
    col = w - 7'd2;
    if (w == 7'd1) return 16'h0000;
    if (disc) return (w == 7'd0) ? 16'h0FFF : 16'h0000;
    if (w == 7'd0) return {10'd0, line};
    return {2'b00, line, col, f0};
  endfunction

`ifdef LEPTON_EMU_CRC_EN
  localparam logic RST_FORCE = 1'b1;

  logic [6:0]  eng_pos, p1, p2;
  logic        eng_f0, f1, f2, eng_busy, eng_to_cur;
  logic [7:0]  eng_byte, eng_data;
  logic [15:0] eng_crc, eng_upd, eng_word, crc_next;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_comb begin
    p1       = adv_pos(head_pos);
    f1       = head_frame[0] ^ (head_pos == LAST_POS);
    p2       = adv_pos(p1);
    f2       = f1 ^ (p1 == LAST_POS);
    eng_word = pkt_word(eng_pos >= FIRST_DISC, eng_pos[5:0], eng_f0, eng_byte[7:1]);
    eng_data = eng_byte[0] ? eng_word[7:0] : eng_word[15:8];
    eng_upd  = crc_byte(eng_crc, eng_data);
  end

  // After reset the engine fills crc_cur for the head packet, then runs one packet ahead into crc_next.
  always_ff @(posedge CLK_25 or posedge RST) begin
    if (RST) begin
      eng_pos    <= 7'd0;
      eng_f0     <= 1'b0;
      eng_byte   <= 8'd0;
      eng_crc    <= 16'h0000;
      eng_busy   <= 1'b1;
      eng_to_cur <= 1'b1;
      crc_cur    <= 16'h0000;
      crc_next   <= 16'h0000;
      cur_valid  <= 1'b0;
    end else if (seq_adv) begin
      crc_cur    <= crc_next;
      eng_pos    <= p2;
      eng_f0     <= f2;
      eng_byte   <= 8'd0;
      eng_crc    <= 16'h0000;
      eng_busy   <= 1'b1;
      eng_to_cur <= 1'b0;
    end else if (eng_busy) begin
      if (eng_byte != 8'd163) begin
        eng_byte <= eng_byte + 8'd1;
        eng_crc  <= eng_upd;
      end else if (eng_to_cur) begin
        crc_cur    <= eng_upd;
        cur_valid  <= 1'b1;
        eng_to_cur <= 1'b0;
        eng_pos    <= p1;
        eng_f0     <= f1;
        eng_byte   <= 8'd0;
        eng_crc    <= 16'h0000;
      end else begin
        crc_next <= eng_upd;
        eng_busy <= 1'b0;
      end
    end
  end
`else
  localparam logic RST_FORCE = 1'b0;
  assign crc_cur   = 16'h0000;
  assign cur_valid = 1'b1;
`endif

  always_comb begin
    state_next   = CAM_CS ? IDLE : SHIFT;
    rise         = ~CAM_CS & CAM_CLK & ~cam_clk_q;
    last_edge    = rise & (bit_cnt == LAST_BIT);
    seq_adv      = last_edge & ~force_disc;
    bit_cnt_next = bit_cnt;
    if (CAM_CS || last_edge) bit_cnt_next = 11'd0;
    else if (rise)           bit_cnt_next = bit_cnt + 11'd1;
    cur_disc     = force_disc | (head_pos >= FIRST_DISC);
    cur_word     = pkt_word(cur_disc, head_pos[5:0], head_frame[0], bit_cnt[10:4]);
    if (bit_cnt[10:4] == 7'd1 && !cur_disc) cur_word = crc_cur;
    CAM_MISO     = ~CAM_CS & cur_word[4'hF - bit_cnt[3:0]];
    dbg_state    = state;
  end

  // cam_clk_q is held high while deselected so a clock already high at CS fall is not an edge.
  always_ff @(posedge CLK_25 or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= 11'd0;
      cam_clk_q  <= 1'b1;
      PKT_SENT   <= 1'b0;
      FRAME_DONE <= 1'b0;
      head_pos   <= 7'd0;
      head_frame <= 8'd0;
      force_disc <= RST_FORCE;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      cam_clk_q  <= CAM_CS | CAM_CLK;
      PKT_SENT   <= last_edge;
      FRAME_DONE <= seq_adv & (head_pos == LAST_LINE);
      if (CAM_CS || last_edge) force_disc <= ~cur_valid;
      if (seq_adv) begin
        head_pos <= adv_pos(head_pos);
        if (head_pos == LAST_POS) head_frame <= head_frame + 8'd1;
      end
    end
  end
endmodule
